hsi_tx_sched: RTL and testbench

//  Frame scheduler for the HSI master transmit path; runs in the CLK_48 domain.

---
 rtl/hsi_tx_sched_pkg.sv | 18 +
 rtl/hsi_tx_sched_frame_timer.sv | 62 ++++++
 rtl/hsi_tx_sched.sv | 152 +++++++++++++++
 tb/tb_hsi_tx_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_tx_sched_pkg.sv
// Shared types and default timing for the HSI master transmit frame scheduler.
package hsi_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTm,
    StSr,
    StWin,
    StCcw
  } sched_state_e;

  localparam int unsigned TickW           = 16;
  localparam int unsigned DefFrameTicks   = 48000;
  localparam int unsigned DefPreTmTicks   = 480;
  localparam int unsigned DefGuardTicks   = 960;
  localparam int unsigned DefAckTimeout   = 255;

endpackage

// File: rtl/hsi_tx_sched_frame_timer.sv
// Frame tick counter, last-tick strobe, registered pre_tm window and frame index.
module hsi_tx_sched_frame_timer
  import hsi_tx_sched_pkg::*;
#(
  parameter int unsigned FRAME_TICKS  = DefFrameTicks,
  parameter int unsigned PRE_TM_TICKS = DefPreTmTicks
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run,
  input  logic             stop,
  input  logic             pre_en,
  input  logic             frame_inc,
  output logic [TickW-1:0] tick_cnt,
  output logic             frame_last,
  output logic             pre_tm,
  output logic [15:0]      frame_num
);

  localparam logic [TickW-1:0] LastTick = TickW'(FRAME_TICKS - 1);
  localparam logic [TickW-1:0] PreStart = TickW'(FRAME_TICKS - PRE_TM_TICKS);

  logic [TickW-1:0] tick_q, tick_d;
  logic [15:0]      frame_num_q, frame_num_d;
  logic             pre_tm_q, pre_tm_d;

  // Frame start lands on the cycle after the last tick, so the FSM acts on this strobe.
  assign frame_last = run && (tick_q == LastTick);

  always_comb begin
    tick_d      = tick_q;
    pre_tm_d    = 1'b0;
    frame_num_d = frame_num_q;
    if (!run || stop || frame_last) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + TickW'(1);
    end
    // pre_tm announces the next frame, so it stays low once the scheduler is stopping.
    pre_tm_d = !stop && pre_en && (tick_d >= PreStart);
    if (frame_inc) begin
      frame_num_d = frame_num_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tick_q      <= '0;
      frame_num_q <= '0;
      pre_tm_q    <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      frame_num_q <= frame_num_d;
      pre_tm_q    <= pre_tm_d;
    end
  end

  assign tick_cnt  = tick_q;
  assign pre_tm    = pre_tm_q;
  assign frame_num = frame_num_q;

endmodule

// File: rtl/hsi_tx_sched.sv
// HSI master transmit frame scheduler: TM slot, SR slot, then a guarded CCW window per frame.
module hsi_tx_sched
  import hsi_tx_sched_pkg::*;
#(
  parameter int unsigned FRAME_TICKS  = DefFrameTicks,
  parameter int unsigned PRE_TM_TICKS = DefPreTmTicks,
  parameter int unsigned GUARD_TICKS  = DefGuardTicks,
  parameter int unsigned ACK_TIMEOUT  = DefAckTimeout
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  output logic        tm_tx_rdy,
  input  logic        tm_tx_ack,
  output logic        pre_tm,
  output logic        sr_tx_rdy,
  input  logic        sr_tx_ack,
  input  logic        ccw_req,
  output logic        ccw_gnt,
  input  logic        ccw_done,
  output logic [15:0] frame_num,
  output logic        overrun,
  output logic        ack_tmo
);

  localparam logic [TickW-1:0] WinClose = TickW'(FRAME_TICKS - PRE_TM_TICKS - GUARD_TICKS);
  localparam int unsigned      TmoW     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(ACK_TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             pend_q, pend_d;
  logic             tm_rdy_q, sr_rdy_q, gnt_q, overrun_q, ack_tmo_q;
  logic             overrun_d, ack_tmo_d;
  logic [TickW-1:0] tick_cnt;
  logic             frame_last;
  logic             frame_inc;

  assign frame_inc = (state_d == StTm) && (state_q != StTm);

  hsi_tx_sched_frame_timer #(
    .FRAME_TICKS  (FRAME_TICKS),
    .PRE_TM_TICKS (PRE_TM_TICKS)
  ) u_frame_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .run        (state_q != StIdle),
    .stop       (state_d == StIdle),
    .pre_en     (en),
    .frame_inc  (frame_inc),
    .tick_cnt   (tick_cnt),
    .frame_last (frame_last),
    .pre_tm     (pre_tm),
    .frame_num  (frame_num)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    overrun_d = 1'b0;
    ack_tmo_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StTm;
        end
      end
      StTm: begin
        if (tm_rdy_q && tm_tx_ack) begin
          state_d = StSr;
        end else if (tmo_q == TmoLast) begin
          state_d   = StSr;
          ack_tmo_d = 1'b1;
        end
        if (frame_last && !en) begin
          state_d = StIdle;
        end
      end
      StSr: begin
        if (sr_rdy_q && sr_tx_ack) begin
          state_d = StWin;
        end else if (tmo_q == TmoLast) begin
          state_d   = StWin;
          ack_tmo_d = 1'b1;
        end
        if (frame_last && !en) begin
          state_d = StIdle;
        end
      end
      StWin: begin
        // Frame end wins over a request; the grant compare uses the current tick.
        if (frame_last) begin
          state_d = en ? StTm : StIdle;
        end else if (ccw_req && en && (tick_cnt < WinClose)) begin
          state_d = StCcw;
        end
      end
      StCcw: begin
        if (ccw_done) begin
          pend_d = 1'b0;
          if (frame_last || pend_q) begin
            state_d = en ? StTm : StIdle;
          end else begin
            state_d = StWin;
          end
        end else if (frame_last) begin
          // TM slot is owed; it is taken right after the CCW finishes.
          pend_d    = 1'b1;
          overrun_d = en;
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = 1'b0;
      end
    endcase

    tmo_d = '0;
    if ((state_d == state_q) && ((state_q == StTm) || (state_q == StSr))) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      pend_q    <= 1'b0;
      tm_rdy_q  <= 1'b0;
      sr_rdy_q  <= 1'b0;
      gnt_q     <= 1'b0;
      overrun_q <= 1'b0;
      ack_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      tm_rdy_q  <= (state_d == StTm);
      sr_rdy_q  <= (state_d == StSr);
      gnt_q     <= (state_d == StCcw);
      overrun_q <= overrun_d;
      ack_tmo_q <= ack_tmo_d;
    end
  end

  assign tm_tx_rdy = tm_rdy_q;
  assign sr_tx_rdy = sr_rdy_q;
  assign ccw_gnt   = gnt_q;
  assign overrun   = overrun_q;
  assign ack_tmo   = ack_tmo_q;

endmodule

// File: tb/tb_hsi_tx_sched.sv
// Directed bench for hsi_tx_sched with a 100-tick frame and hand-derived expectations.
module tb_hsi_tx_sched;

  localparam int FT = 100;

  logic        clk = 1'b0;
  logic        n_rst, en, tm_tx_ack, sr_tx_ack, ccw_req, ccw_done;
  logic        tm_tx_rdy, pre_tm, sr_tx_rdy, ccw_gnt, overrun, ack_tmo;
  logic [15:0] frame_num;

  int n_checks = 0;
  int n_fail   = 0;
  int tick     = 0;

  always #5 clk = ~clk;

  hsi_tx_sched #(
    .FRAME_TICKS  (100),
    .PRE_TM_TICKS (10),
    .GUARD_TICKS  (20),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .tm_tx_rdy (tm_tx_rdy),
    .tm_tx_ack (tm_tx_ack),
    .pre_tm    (pre_tm),
    .sr_tx_rdy (sr_tx_rdy),
    .sr_tx_ack (sr_tx_ack),
    .ccw_req   (ccw_req),
    .ccw_gnt   (ccw_gnt),
    .ccw_done  (ccw_done),
    .frame_num (frame_num),
    .overrun   (overrun),
    .ack_tmo   (ack_tmo)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Output vector order: {tm_tx_rdy, sr_tx_rdy, pre_tm, ccw_gnt, overrun, ack_tmo}
  task automatic check_outs(input string tag, input logic [5:0] exp);
    logic [5:0] act;
    act = {tm_tx_rdy, sr_tx_rdy, pre_tm, ccw_gnt, overrun, ack_tmo};
    check_val(tag, {26'd0, act}, {26'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = (tick + 1) % FT;
  endtask

  task automatic step_to(input int t);
    while (tick != t) step();
  endtask

  // From tick 0 of a frame: ack TM on tick 2, SR on tick 4; WIN from tick 5.
  task automatic handshake();
    step_to(2);
    tm_tx_ack = 1'b1;
    step();
    tm_tx_ack = 1'b0;
    step();
    sr_tx_ack = 1'b1;
    step();
    sr_tx_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst     = 1'b0;
    en        = 1'b0;
    tm_tx_ack = 1'b0;
    sr_tx_ack = 1'b0;
    ccw_req   = 1'b0;
    ccw_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("rst_outs", 6'b000000);
    check_val("rst_fnum", {16'd0, frame_num}, 32'd0);
    n_rst = 1'b1;
    step();
    check_outs("idle_outs", 6'b000000);

    // 1: first frame, TM/SR handshakes, pre_tm window
    en = 1'b1;
    step();
    tick = 0;
    check_outs("t1_tm_rdy", 6'b100000);
    check_val("t1_fnum1", {16'd0, frame_num}, 32'd1);
    step();
    step();
    check_val("t1_tm_rdy_t2", {31'd0, tm_tx_rdy}, 32'd1);
    tm_tx_ack = 1'b1;
    step();
    tm_tx_ack = 1'b0;
    check_outs("t1_sr_rdy", 6'b010000);
    step();
    sr_tx_ack = 1'b1;
    step();
    sr_tx_ack = 1'b0;
    check_outs("t1_win", 6'b000000);
    step_to(89);
    check_val("t1_pre89", {31'd0, pre_tm}, 32'd0);
    step();
    check_val("t1_pre90", {31'd0, pre_tm}, 32'd1);
    step_to(99);
    check_val("t1_pre99", {31'd0, pre_tm}, 32'd1);
    step();
    check_outs("t1_f2_start", 6'b100000);
    check_val("t1_fnum2", {16'd0, frame_num}, 32'd2);

    // 2: CCW grant in window, no grant at window close
    handshake();
    step_to(40);
    ccw_req = 1'b1;
    step();
    check_outs("t2_gnt41", 6'b000100);
    step_to(51);
    check_val("t2_gnt51", {31'd0, ccw_gnt}, 32'd1);
    ccw_done = 1'b1;
    ccw_req  = 1'b0;
    step();
    ccw_done = 1'b0;
    check_val("t2_gnt_drop", {31'd0, ccw_gnt}, 32'd0);
    step_to(70);
    ccw_req = 1'b1;
    step();
    check_val("t2_nogrant71", {31'd0, ccw_gnt}, 32'd0);
    step();
    check_val("t2_nogrant72", {31'd0, ccw_gnt}, 32'd0);
    ccw_req = 1'b0;

    // 3: CCW overruns into next frame, late TM slot
    step_to(99);
    step();
    check_val("t3_fnum3", {16'd0, frame_num}, 32'd3);
    handshake();
    step_to(68);
    ccw_req = 1'b1;
    step();
    ccw_req = 1'b0;
    check_val("t3_gnt69", {31'd0, ccw_gnt}, 32'd1);
    step_to(99);
    check_outs("t3_t99", 6'b001100);
    step();
    check_outs("t3_overrun", 6'b000110);
    check_val("t3_fnum_hold", {16'd0, frame_num}, 32'd3);
    step();
    check_outs("t3_overrun_end", 6'b000100);
    step_to(5);
    ccw_done = 1'b1;
    step();
    ccw_done = 1'b0;
    check_outs("t3_late_tm", 6'b100000);
    check_val("t3_fnum4", {16'd0, frame_num}, 32'd4);

    // 4: TM ack never arrives
    step_to(13);
    check_outs("t4_t13", 6'b100000);
    step();
    check_outs("t4_tmo", 6'b010001);
    step();
    check_outs("t4_tmo_end", 6'b010000);
    sr_tx_ack = 1'b1;
    step();
    sr_tx_ack = 1'b0;
    check_outs("t4_win", 6'b000000);

    // Stray acks and ccw_done in WIN are ignored
    step_to(20);
    tm_tx_ack = 1'b1;
    sr_tx_ack = 1'b1;
    ccw_done  = 1'b1;
    step();
    tm_tx_ack = 1'b0;
    sr_tx_ack = 1'b0;
    ccw_done  = 1'b0;
    check_outs("stray_ack", 6'b000000);

    // 5: en falls mid-frame
    step_to(50);
    en      = 1'b0;
    ccw_req = 1'b1;
    step();
    check_outs("t5_nogrant", 6'b000000);
    step_to(95);
    check_val("t5_no_pre", {31'd0, pre_tm}, 32'd0);
    step_to(99);
    step();
    check_outs("t5_idle", 6'b000000);
    repeat (5) step();
    check_outs("t5_idle_hold", 6'b000000);
    check_val("t5_fnum_hold", {16'd0, frame_num}, 32'd4);
    ccw_req = 1'b0;

    // 6: async reset during CCW
    en = 1'b1;
    step();
    tick = 0;
    check_val("t6_fnum5", {16'd0, frame_num}, 32'd5);
    handshake();
    step_to(30);
    ccw_req = 1'b1;
    step();
    check_val("t6_gnt", {31'd0, ccw_gnt}, 32'd1);
    step_to(35);
    n_rst = 1'b0;
    #1;
    check_outs("t6_rst_outs", 6'b000000);
    check_val("t6_rst_fnum", {16'd0, frame_num}, 32'd0);
    step();
    ccw_req = 1'b0;
    n_rst   = 1'b1;
    step();
    check_outs("t6_tm_after_rst", 6'b100000);
    check_val("t6_fnum1", {16'd0, frame_num}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
